// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral responder: register offsets,
// TCON bit positions and the active-low hex glyph table.
package mmio_pkg;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_DISP    = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN     = 0;
    localparam int TCON_IRQ_EN = 1;
    localparam int TCON_STATUS = 2;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    // Segments {g,f,e,d,c,b,a}, active-low, for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/mmio_periph_resp_seg7_scan.sv
// Four-digit multiplexed 7-segment scan driver: a divider paces the digit
// index, which selects one nibble of value and drives its active-low glyph.
module seg7_scan
    import mmio_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int SCAN_CNT_W = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [3:0]  AN,
    output logic [7:0]  BCD
);

    localparam logic [SCAN_CNT_W-1:0] CNT_LAST = SCAN_CNT_W'(SCAN_DIV - 1);

    logic [SCAN_CNT_W-1:0] div_r;
    logic [1:0]            idx_r;
    logic [3:0]            nibble_s;

    // Divider and digit index; the index advances only when the divider wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
            idx_r <= 2'd0;
        end else if (div_r == CNT_LAST) begin
            div_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            div_r <= div_r + {{(SCAN_CNT_W-1){1'b0}}, 1'b1};
            idx_r <= idx_r;
        end
    end

    // Select the nibble for the currently lit digit.
    always_comb begin
        nibble_s = 4'h0;
        case (idx_r)
            2'd0:    nibble_s = value[3:0];
            2'd1:    nibble_s = value[7:4];
            2'd2:    nibble_s = value[11:8];
            2'd3:    nibble_s = value[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    assign AN  = ~(4'b0001 << idx_r);
    assign BCD = {1'b1, seg_glyph(nibble_s)};

endmodule

// File: rtl/mmio_periph_resp.sv
// MMIO peripheral responder at the MEM stage: timer with interrupt, LED and
// display registers. Define MMIO_SYSTICK_EN to build the free-running SYSTICK.
module mmio_periph_resp
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          SCAN_DIV   = 100000,
    parameter int          SCAN_CNT_W = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        irq,
    output logic [15:0] led,
    output logic [3:0]  AN,
    output logic [7:0]  BCD
);

    logic [31:0] th_r, tl_r;
    logic [2:0]  tcon_r;
    logic [15:0] led_r, disp_r;

    logic [31:0] th_nxt_s, tl_nxt_s;
    logic [2:0]  tcon_nxt_s;
    logic [15:0] led_nxt_s, disp_nxt_s;

    logic        hit_s, wr_s, ovf_s, set_s;
    logic [4:0]  off_s;
    logic        th_we_s, tl_we_s, tcon_we_s, led_we_s, disp_we_s;
    logic [31:0] rdata_s;

`ifdef MMIO_SYSTICK_EN
    logic [31:0] systick_r, systick_nxt_s;
    logic        systick_we_s;
`endif

    assign hit_s = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
    assign off_s = Address[4:0];
    assign wr_s  = hit_s & MemWrite;

    // Decode per-register write enables from the store strobe.
    always_comb begin
        th_we_s   = 1'b0;
        tl_we_s   = 1'b0;
        tcon_we_s = 1'b0;
        led_we_s  = 1'b0;
        disp_we_s = 1'b0;
`ifdef MMIO_SYSTICK_EN
        systick_we_s = 1'b0;
`endif
        if (wr_s) begin
            case (off_s)
                OFF_TH:   th_we_s   = 1'b1;
                OFF_TL:   tl_we_s   = 1'b1;
                OFF_TCON: tcon_we_s = 1'b1;
                OFF_LED:  led_we_s  = 1'b1;
                OFF_DISP: disp_we_s = 1'b1;
`ifdef MMIO_SYSTICK_EN
                OFF_SYSTICK: systick_we_s = 1'b1;
`endif
                default:  th_we_s   = 1'b0;
            endcase
        end else begin
            th_we_s = 1'b0;
        end
    end

    // Overflow is judged on the current count so a same-cycle TL store cannot hide it.
    assign ovf_s = tcon_r[TCON_EN] && (tl_r == TL_MAX);
    assign set_s = ovf_s && tcon_r[TCON_IRQ_EN];

    // Next-state for all CPU-visible registers; CPU stores win over timer updates,
    // except that a hardware status set beats a software clear.
    always_comb begin
        th_nxt_s   = th_r;
        tl_nxt_s   = tl_r;
        tcon_nxt_s = tcon_r;
        led_nxt_s  = led_r;
        disp_nxt_s = disp_r;

        if (th_we_s) begin
            th_nxt_s = Write_data;
        end else begin
            th_nxt_s = th_r;
        end

        if (tl_we_s) begin
            tl_nxt_s = Write_data;
        end else if (ovf_s) begin
            tl_nxt_s = th_r;
        end else if (tcon_r[TCON_EN]) begin
            tl_nxt_s = tl_r + 32'd1;
        end else begin
            tl_nxt_s = tl_r;
        end

        if (tcon_we_s) begin
            tcon_nxt_s[TCON_EN]     = Write_data[TCON_EN];
            tcon_nxt_s[TCON_IRQ_EN] = Write_data[TCON_IRQ_EN];
            tcon_nxt_s[TCON_STATUS] = Write_data[TCON_STATUS] | set_s;
        end else begin
            tcon_nxt_s[TCON_STATUS] = tcon_r[TCON_STATUS] | set_s;
        end

        if (led_we_s) begin
            led_nxt_s = Write_data[15:0];
        end else begin
            led_nxt_s = led_r;
        end

        if (disp_we_s) begin
            disp_nxt_s = Write_data[15:0];
        end else begin
            disp_nxt_s = disp_r;
        end
    end

    // Register state; reset also discards any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_r   <= 32'h0;
            tl_r   <= 32'h0;
            tcon_r <= 3'b000;
            led_r  <= 16'h0;
            disp_r <= 16'h0;
        end else begin
            th_r   <= th_nxt_s;
            tl_r   <= tl_nxt_s;
            tcon_r <= tcon_nxt_s;
            led_r  <= led_nxt_s;
            disp_r <= disp_nxt_s;
        end
    end

`ifdef MMIO_SYSTICK_EN
    // Free-running tick counter; a store replaces that cycle's increment.
    always_comb begin
        systick_nxt_s = systick_r + 32'd1;
        if (systick_we_s) begin
            systick_nxt_s = Write_data;
        end else begin
            systick_nxt_s = systick_r + 32'd1;
        end
    end

    // SYSTICK register.
    always_ff @(posedge clk) begin
        if (reset) begin
            systick_r <= 32'h0;
        end else begin
            systick_r <= systick_nxt_s;
        end
    end
`endif

    // Zero-latency load mux; returns the pre-store value when both strobes are high.
    always_comb begin
        rdata_s = 32'h0;
        if (hit_s && MemRead) begin
            case (off_s)
                OFF_TH:   rdata_s = th_r;
                OFF_TL:   rdata_s = tl_r;
                OFF_TCON: rdata_s = {29'h0, tcon_r};
                OFF_LED:  rdata_s = {16'h0, led_r};
                OFF_DISP: rdata_s = {16'h0, disp_r};
`ifdef MMIO_SYSTICK_EN
                OFF_SYSTICK: rdata_s = systick_r;
`endif
                default:  rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign Read_data = rdata_s;
    assign hit       = hit_s;
    assign irq       = tcon_r[TCON_IRQ_EN] & tcon_r[TCON_STATUS];
    assign led       = led_r;

    seg7_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .SCAN_CNT_W (SCAN_CNT_W)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .value (disp_r),
        .AN    (AN),
        .BCD   (BCD)
    );

endmodule

// File: tb/tb_mmio_periph_resp.sv
// Directed self-checking bench for mmio_periph_resp (scan divider shortened to 4).
module tb_mmio_periph_resp;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, Write_data, Read_data;
    logic        MemRead, MemWrite, hit, irq;
    logic [15:0] led;
    logic [3:0]  AN;
    logic [7:0]  BCD;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_periph_resp #(
        .BASE_ADDR  (BASE),
        .SCAN_DIV   (4),
        .SCAN_CNT_W (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .hit        (hit),
        .irq        (irq),
        .led        (led),
        .AN         (AN),
        .BCD        (BCD)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
        Address    = 32'h0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] off, input logic [31:0] exp);
        Address = BASE + {27'h0, off};
        MemRead = 1'b1;
        #1;
        check_eq(tag, Read_data, exp);
        MemRead = 1'b0;
        Address = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Address = 32'h0; Write_data = 32'h0;
        MemRead = 1'b0; MemWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("reset_rd_%0d", i), 5'(i * 4), 32'h0);
        end
        check_eq("reset_an", {28'h0, AN}, 32'h0000_000E);
        check_eq("reset_bcd", {24'h0, BCD}, 32'h0000_00C0);
        check_eq("reset_irq", {31'h0, irq}, 32'h0);
        check_eq("reset_led", {16'h0, led}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // LED store / load, misaligned store, read-during-write
        bus_write(BASE + 32'h0C, 32'h0000_A5A5);
        check_eq("led_after_wr", {16'h0, led}, 32'h0000_A5A5);
        read_check("led_rd", 5'h0C, 32'h0000_A5A5);
        @(negedge clk);
        Address = BASE + 32'h0E; Write_data = 32'h0000_1111; MemWrite = 1'b1;
        #1;
        check_eq("misalign_hit", {31'h0, hit}, 32'h0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        check_eq("misalign_led", {16'h0, led}, 32'h0000_A5A5);
        @(negedge clk);
        Address = BASE + 32'h0C; Write_data = 32'h0000_1234;
        MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        check_eq("rw_hit", {31'h0, hit}, 32'h1);
        check_eq("rw_pre_value", Read_data, 32'h0000_A5A5);
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        check_eq("rw_led", {16'h0, led}, 32'h0000_1234);

        // Reset discards a same-cycle store
        @(negedge clk);
        reset = 1'b1; Address = BASE + 32'h0C; Write_data = 32'h0000_FFFF; MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0; reset = 1'b0;
        check_eq("rst_store_led", {16'h0, led}, 32'h0);

        // Timer reload and interrupt
        bus_write(BASE + 32'h00, 32'hFFFF_FFFD);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h08, 32'h0000_0003);
        read_check("tl_start", 5'h04, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        read_check("tl_max", 5'h04, 32'hFFFF_FFFF);
        check_eq("irq_before_ovf", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        read_check("tl_reload", 5'h04, 32'hFFFF_FFFD);
        check_eq("irq_after_ovf", {31'h0, irq}, 32'h1);
        read_check("tcon_status", 5'h08, 32'h0000_0007);
        @(posedge clk); #1;
        read_check("tl_after_reload", 5'h04, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h08, 32'h0000_0003);
        check_eq("irq_cleared", {31'h0, irq}, 32'h0);
        read_check("tl_at_max_again", 5'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'h0000_0003);
        check_eq("irq_set_beats_clear", {31'h0, irq}, 32'h1);
        read_check("tcon_set_beats_clear", 5'h08, 32'h0000_0007);
        read_check("tl_reload2", 5'h04, 32'hFFFF_FFFD);
        bus_write(BASE + 32'h04, 32'h0000_0100);
        read_check("tl_write_override", 5'h04, 32'h0000_0100);
        bus_write(BASE + 32'h08, 32'h0000_0000);
        check_eq("irq_off", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        read_check("tl_frozen", 5'h04, 32'h0000_0101);

        // SYSTICK
        do_reset();
        repeat (10) @(posedge clk);
        #1;
`ifdef MMIO_SYSTICK_EN
        read_check("systick_10", 5'h14, 32'd10);
`else
        read_check("systick_absent", 5'h14, 32'h0);
`endif
        bus_write(BASE + 32'h14, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
`ifdef MMIO_SYSTICK_EN
        read_check("systick_wrap", 5'h14, 32'd1);
`else
        read_check("systick_wr_ignored", 5'h14, 32'h0);
`endif

        // Display scan, phase known from the reset release
        do_reset();
        bus_write(BASE + 32'h10, 32'h0000_12EF);
        check_eq("scan0_an", {28'h0, AN}, 32'h0000_000E);
        check_eq("scan0_bcd", {24'h0, BCD}, 32'h0000_008E);
        repeat (2) @(posedge clk); #1;
        check_eq("scan0_hold_an", {28'h0, AN}, 32'h0000_000E);
        @(posedge clk); #1;
        check_eq("scan1_an", {28'h0, AN}, 32'h0000_000D);
        check_eq("scan1_bcd", {24'h0, BCD}, 32'h0000_0086);
        repeat (4) @(posedge clk); #1;
        check_eq("scan2_an", {28'h0, AN}, 32'h0000_000B);
        check_eq("scan2_bcd", {24'h0, BCD}, 32'h0000_00A4);
        repeat (4) @(posedge clk); #1;
        check_eq("scan3_an", {28'h0, AN}, 32'h0000_0007);
        check_eq("scan3_bcd", {24'h0, BCD}, 32'h0000_00F9);
        repeat (4) @(posedge clk); #1;
        check_eq("scan_wrap_an", {28'h0, AN}, 32'h0000_000E);
        check_eq("scan_wrap_bcd", {24'h0, BCD}, 32'h0000_008E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
